// File: rtl/ipv4_vlg_tx_arb.sv
// ipv4_vlg_tx_arb: round-robin arbiter that hands the IPv4 TX path to one of N
// packet sources (0 = ICMP, 1 = UDP, 2 = TCP) and muxes its byte stream out.
// Optional packet watchdog compiled in with `define IPV4_VLG_TX_ARB_WATCHDOG_EN.
module ipv4_vlg_tx_arb #(
    parameter int unsigned N       = 3,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req,
    input  logic [N*8-1:0]         in_dat,
    input  logic [N-1:0]           in_val,
    input  logic [N-1:0]           in_sof,
    input  logic [N-1:0]           in_eof,
    output logic [N-1:0]           gnt,
    input  logic                   tx_rdy,
    input  logic                   tx_done,
    output logic [7:0]             out_dat,
    output logic                   out_val,
    output logic                   out_sof,
    output logic                   out_eof,
    output logic [$clog2(N)-1:0]   out_sel,
    output logic                   err_to
);

    localparam int unsigned SEL_W = $clog2(N);
    localparam int unsigned DAT_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        XFER      = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [N-1:0]       gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [DAT_W-1:0]   dat_q, dat_d;
    logic               val_q, val_d;
    logic               sof_q, sof_d;
    logic               eof_q, eof_d;

    logic [SEL_W-1:0]   pick_c;
    logic               found_c;
    int unsigned        idx_c;
    logic               grant_c;
    logic [DAT_W-1:0]   mux_dat_c;
    logic               mux_val_c, mux_sof_c, mux_eof_c;
    logic               eof_hit_c;
    logic               wd_hit_c;

    // Round-robin pick: first requesting index at or after ptr
    always_comb begin
        pick_c  = '0;
        found_c = 1'b0;
        idx_c   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx_c = (32'(ptr_q) + k) % N;
            if (!found_c && req[SEL_W'(idx_c)]) begin
                found_c = 1'b1;
                pick_c  = SEL_W'(idx_c);
            end
        end
    end

    assign grant_c = (state_q == IDLE) && tx_rdy && found_c;

    // Stream mux: only the granted lane reaches the output path
    always_comb begin
        mux_dat_c = '0;
        mux_val_c = 1'b0;
        mux_sof_c = 1'b0;
        mux_eof_c = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel_q == SEL_W'(i)) begin
                mux_dat_c = in_dat[DAT_W*i +: DAT_W];
                mux_val_c = in_val[i];
                mux_sof_c = in_sof[i];
                mux_eof_c = in_eof[i];
            end
        end
    end

    assign eof_hit_c = (state_q == XFER) && mux_val_c && mux_eof_c;

`ifdef IPV4_VLG_TX_ARB_WATCHDOG_EN
    localparam int unsigned WD_W = 16;

    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_to_q, err_to_d;

    assign wd_hit_c = (state_q != IDLE) && (wd_q == WD_W'(TIMEOUT - 1));

    // Watchdog count: restarts on every grant, runs while a packet owns the path
    always_comb begin
        wd_d     = wd_q;
        err_to_d = wd_hit_c;
        if (grant_c) begin
            wd_d = '0;
        end else if (state_q != IDLE) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    // Watchdog registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q     <= '0;
            err_to_q <= 1'b0;
        end else begin
            wd_q     <= wd_d;
            err_to_q <= err_to_d;
        end
    end

    assign err_to = err_to_q;
`else
    logic wd_unused;

    assign wd_unused = |32'(TIMEOUT);
    assign wd_hit_c  = 1'b0;
    assign err_to    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: grant, stream to eof, wait for TX completion; watchdog overrides
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_c) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (eof_hit_c) begin
                    state_d = tx_done ? IDLE : WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (wd_hit_c) begin
            state_d = IDLE;
        end
    end

    // Output/datapath next values; qualifiers are only live while in XFER
    always_comb begin
        gnt_d = gnt_q;
        sel_d = sel_q;
        ptr_d = ptr_q;
        dat_d = '0;
        val_d = 1'b0;
        sof_d = 1'b0;
        eof_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_c) begin
                    gnt_d = N'(1) << pick_c;
                    sel_d = pick_c;
                    ptr_d = SEL_W'((32'(pick_c) + 1) % N);
                end
            end
            XFER: begin
                dat_d = mux_dat_c;
                val_d = mux_val_c;
                sof_d = mux_sof_c;
                eof_d = mux_eof_c;
                if (eof_hit_c && tx_done) begin
                    gnt_d = '0;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    gnt_d = '0;
                end
            end
            default: gnt_d = '0;
        endcase
        if (wd_hit_c) begin
            gnt_d = '0;
            if (state_q == XFER) begin
                dat_d = '0;
                val_d = 1'b0;
                sof_d = 1'b0;
                eof_d = 1'b1;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q <= '0;
            sel_q <= '0;
            ptr_q <= '0;
            dat_q <= '0;
            val_q <= 1'b0;
            sof_q <= 1'b0;
            eof_q <= 1'b0;
        end else begin
            gnt_q <= gnt_d;
            sel_q <= sel_d;
            ptr_q <= ptr_d;
            dat_q <= dat_d;
            val_q <= val_d;
            sof_q <= sof_d;
            eof_q <= eof_d;
        end
    end

    assign gnt     = gnt_q;
    assign out_sel = sel_q;
    assign out_dat = dat_q;
    assign out_val = val_q;
    assign out_sof = sof_q;
    assign out_eof = eof_q;

endmodule
